// File: rtl/conv_bcd_display_if.sv
// -----------------------------------------------------------------------------
// conv_bcd_display_if
//
// Purpose:
//   Bundles the request, result and display-pin signals of conv_bcd_display.
//   The requester (the dual converter side, or a testbench) uses the master
//   modport. The display stage uses the slave modport.
//
// Signals:
//   start     master->slave  1  request to convert data_in
//   data_in   master->slave  6  binary value 0..63
//   busy      slave->master  1  conversion in progress
//   done      slave->master  1  one-cycle pulse: bcd_tens/bcd_ones updated
//   bcd_tens  slave->master  4  tens digit 0..6
//   bcd_ones  slave->master  4  ones digit 0..9
//   seg       slave->master  7  segment drive, active-low {g,f,e,d,c,b,a}
//   an        slave->master  2  digit enables, active-low (an[0] = ones)
// -----------------------------------------------------------------------------
interface conv_bcd_display_if;
  logic       start;
  logic [5:0] data_in;
  logic       busy;
  logic       done;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  bcd_tens,
    input  bcd_ones,
    input  seg,
    input  an
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output bcd_tens,
    output bcd_ones,
    output seg,
    output an
  );
endinterface

// File: rtl/conv_bcd_display.sv
// -----------------------------------------------------------------------------
// conv_bcd_display
//
// Purpose:
//   Display stage for the 6-bit dual converter result. A start pulse captures
//   a binary value 0..63. A sequential shift-add-3 (double-dabble) engine
//   converts it to two BCD digits over 6 clocks. The digits drive a two-digit,
//   time-multiplexed, common-anode 7-segment display.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit before switching (2..2^20)
//
// Ports:
//   clk   input   system clock, rising-edge
//   rst   input   synchronous, active-high reset
//   bus   slave   conv_bcd_display_if (start/data_in in; busy, done,
//                 bcd_tens, bcd_ones, seg, an out)
//
// Optional feature:
//   BLANK_LEADING_ZERO_EN - when defined, the tens digit is switched off
//   (an = 2'b11) during its refresh slot whenever bcd_tens is 0.
// -----------------------------------------------------------------------------
module conv_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  conv_bcd_display_if.slave  bus
);

  localparam int BIN_W   = 6;
  localparam int NUM_NIB = 2;
  localparam int WORK_W  = BIN_W + 4 * NUM_NIB;
  localparam int CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Active-low {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [WORK_W-1:0]   work_q;
  logic [2:0]          bit_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [3:0]          tens_q;
  logic [3:0]          ones_q;

  logic [WORK_W-1:0]   work_adj;
  logic [WORK_W-1:0]   work_shl;
  logic                conv_last;
  logic [3:0]          tens_d;
  logic [3:0]          ones_d;

  // Working register layout: [13:10] tens, [9:6] ones, [5:0] binary input.
  // The binary bits are never adjusted, only shifted up into the nibbles.
  assign work_adj[BIN_W-1:0] = work_q[BIN_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = work_q[BIN_W + 4*gi +: 4];
      // A nibble of 5..9 would become >= 10 after the shift; pre-adding 3
      // makes the shift carry correctly into the next decimal digit.
      assign work_adj[BIN_W + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign work_shl  = {work_adj[WORK_W-2:0], 1'b0};

  // The shift performed on this edge is the last one of the conversion.
  assign conv_last = (state_q == SHIFT) && (bit_cnt_q == 3'(BIN_W - 1));

  // Digit values as they will be after this edge; the display path uses these
  // so seg changes on the same edge that bcd_tens/bcd_ones update.
  assign tens_d = conv_last ? work_shl[BIN_W + 4 +: 4] : tens_q;
  assign ones_d = conv_last ? work_shl[BIN_W     +: 4] : ones_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      done_q <= 1'b0;
      tens_q <= tens_d;
      ones_q <= ones_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q    <= {{(WORK_W-BIN_W){1'b0}}, bus.data_in};
            bit_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // start and data_in are deliberately not looked at here
          work_q    <= work_shl;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (conv_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] refresh_cnt_q;
  logic [CNT_W-1:0] refresh_cnt_d;
  logic             sel_tens_q;
  logic             sel_tens_d;
  logic             refresh_wrap;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;
  logic [1:0]       an_q;
  logic [1:0]       an_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign refresh_wrap = (refresh_cnt_q == CNT_LAST);

  always_comb begin
    refresh_cnt_d = refresh_wrap ? '0 : (refresh_cnt_q + CNT_W'(1));
    sel_tens_d    = sel_tens_q ^ refresh_wrap;
    seg_d         = seg_encode(sel_tens_d ? tens_d : ones_d);
    an_d          = 2'b10;
    if (sel_tens_d) begin
`ifdef BLANK_LEADING_ZERO_EN
      an_d = (tens_d == 4'd0) ? 2'b11 : 2'b01;
`else
      an_d = 2'b01;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      sel_tens_q    <= 1'b0;
      seg_q         <= 7'b1000000;
      an_q          <= 2'b10;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      sel_tens_q    <= sel_tens_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
  assign bus.seg      = seg_q;
  assign bus.an       = an_q;

endmodule

// File: doc/conv_bcd_display.md
Name: conv_bcd_display

Overview:
Downstream display stage for the 6-bit dual converter result.
- Captures a 6-bit binary value (0..63) on a start pulse.
- Converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a two-digit, time-multiplexed, common-anode 7-segment display.
- Sits between the dual converter's 6-bit output and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit before switching. Legal range 2..2^20.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request to convert data_in; sampled on the rising edge.
- data_in  input  6  binary value to display (dual converter output).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_tens/bcd_ones have been updated.
- bcd_tens  output  4  tens digit, 0..6.
- bcd_ones  output  4  ones digit, 0..9.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  2  digit enables, active-low; an[0] = ones digit, an[1] = tens digit.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values (registered on the edge where rst=1):
  - FSM = IDLE; busy=0; done=0.
  - bcd_tens=0; bcd_ones=0.
  - refresh counter = 0; digit select = ones; an=2'b10; seg=7'b1000000.
- rst overrides everything, including a conversion in progress. Partial results are discarded and bcd outputs return to 0.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - If start=1 at edge k: load a 14-bit shift register with {8'b0, data_in}, clear the bit counter to 0, go to SHIFT. busy=1 from edge k.
  - If start=0: remain in IDLE.
- SHIFT, per edge:
  - For each BCD nibble of the working register, add 3 if the nibble is >=5.
  - Then shift the whole register left by 1 and increment the bit counter.
  - After the 6th shift (edge k+6): register the BCD nibbles into bcd_tens/bcd_ones, set done=1 for exactly that cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle following edge k+6, i.e. 6 cycles after start is sampled.
- start while busy=1 is ignored; data_in is not resampled.
- start in the cycle where done=1 is accepted, so back-to-back conversions run every 7 cycles.
- bcd_tens/bcd_ones hold their value until the next done.
- Display refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, digit select toggles.
  - When ones is selected: an=2'b10 and seg shows bcd_ones. When tens is selected: an=2'b01 and seg shows bcd_tens.
  - seg and an are registered and change on the same edge.
  - The refresh counter runs independently of the conversion FSM.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value shows 1111111 (blank); unreachable in normal operation.

Optional Feature:
- Macro BLANK_LEADING_ZERO_EN.
- When defined: while tens is selected and bcd_tens==0, an=2'b11 (both digits off). Ones-digit behaviour is unchanged.
- When undefined: the tens digit is always driven, and shows "0" for values below 10.

Test Plan:
- rst=1 for 2 cycles, then rst=0 -> busy=0, done=0, bcd_tens=0, bcd_ones=0, an=2'b10, seg=7'b1000000.
- data_in=6'b011001, start pulse at edge k -> busy=1 for edges k..k+5, done=1 after edge k+6, bcd_tens=2, bcd_ones=5.
- data_in=6'd63, then 6'd0, then 6'd10 converted back-to-back, each start issued in the done cycle -> (6,3), (0,0), (1,0); each done arrives exactly 7 cycles apart.
- start with data_in=14 accepted, then start with data_in=20 held during busy -> only one done, result (1,4).
- Conversion of 63 started, rst=1 at edge k+3 -> busy=0, no done pulse, bcd=(0,0); a new start afterwards completes normally.
- REFRESH_DIV=4, value 9 converted -> an alternates 10/01 every 4 cycles, seg=0010000 on ones; tens shows 1000000 without the macro, and an=2'b11 during the tens phase with BLANK_LEADING_ZERO_EN defined.
